// File: rtl/fft16_pkg.sv
// Shared constants and types for the 16-point FFT datapath and its output-side helpers.
package fft16_pkg;

    localparam int N_BINS        = 16;
    localparam int BIN_W         = 4;
    localparam int WORD_SIZE_DEF = 16;
    localparam int FRACTION_DEF  = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [WORD_SIZE_DEF-1:0] re;
        logic signed [WORD_SIZE_DEF-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft16_bin_streamer_if.sv
// Per-bin output stream of the bin streamer, one beat per valid/ready handshake.
interface fft16_bin_streamer_if #(
    parameter int WORD_SIZE = 16
);
    // A beat transfers on a rising edge where o_valid && i_ready; while o_valid is
    // high and i_ready is low every payload signal holds, and o_valid only falls
    // after a transfer (or on reset).
    logic                        o_valid;
    logic                        i_ready;
    logic signed [WORD_SIZE-1:0] o_re;
    logic signed [WORD_SIZE-1:0] o_im;
    logic        [WORD_SIZE:0]   o_mag;
    logic        [3:0]           o_bin;
    logic                        o_last;

    modport master (
        output o_valid, o_re, o_im, o_mag, o_bin, o_last,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_re, o_im, o_mag, o_bin, o_last,
        output i_ready
    );

endinterface

// File: rtl/fft16_bin_streamer_abs_sum.sv
// L1 magnitude |re|+|im| of one complex word, exact for the most negative input.
module fft_abs_sum #(
    parameter int W = 16
) (
    input  logic [W-1:0] re_i,
    input  logic [W-1:0] im_i,
    output logic [W:0]   mag_o
);

    logic [W-1:0] abs_re;
    logic [W-1:0] abs_im;

    // Treated as unsigned, the negation of 2^(W-1) is 2^(W-1) itself.
    assign abs_re = re_i[W-1] ? (~re_i + 1'b1) : re_i;
    assign abs_im = im_i[W-1] ? (~im_i + 1'b1) : im_i;
    assign mag_o  = {1'b0, abs_re} + {1'b0, abs_im};

endmodule

// File: rtl/fft16_bin_streamer.sv
// Captures the 16 FFT bins on a done pulse and streams them one bin per handshake.
module fft16_bin_streamer
    import fft16_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int FRACTION  = FRACTION_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [N_BINS*WORD_SIZE-1:0]   i_bins_re,
    input  logic [N_BINS*WORD_SIZE-1:0]   i_bins_im,
    input  logic                          i_FFT_cycle_done,
    fft16_bin_streamer_if.master          strm,
    output logic                          o_busy,
    output logic                          o_overrun,
    input  logic                          i_clr_overrun,
    output state_t                        o_state_dbg
);

    if (FRACTION > WORD_SIZE) begin : g_bad_fraction
        $error("FRACTION must not exceed WORD_SIZE");
    end

    state_t                 state_q, state_d;
    logic [BIN_W-1:0]       idx_q, idx_d;
    logic                   overrun_q, overrun_d;
    logic [WORD_SIZE-1:0]   re_q [N_BINS];
    logic [WORD_SIZE-1:0]   im_q [N_BINS];
    logic                   handshake, at_last, capture, drop;

    assign handshake = (state_q == STREAM) && strm.i_ready;
    assign at_last   = (idx_q == BIN_W'(N_BINS - 1));
    // A done pulse is only accepted when the bank is free or frees up this very cycle.
    assign capture   = i_FFT_cycle_done && ((state_q == IDLE) || (handshake && at_last));
    assign drop      = i_FFT_cycle_done && (state_q == STREAM) && !(handshake && at_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_BINS; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < N_BINS; k++) begin
                re_q[k] <= i_bins_re[k*WORD_SIZE +: WORD_SIZE];
                im_q[k] <= i_bins_im[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE:   if (i_FFT_cycle_done) state_d = STREAM;
            STREAM: if (handshake && at_last && !i_FFT_cycle_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (capture) begin
            idx_d = '0;
        end else if (handshake) begin
            idx_d = idx_q + 1'b1;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    fft_abs_sum #(.W(WORD_SIZE)) u_abs_sum (
        .re_i  (re_q[idx_q]),
        .im_i  (im_q[idx_q]),
        .mag_o (strm.o_mag)
    );

    always_comb begin
        strm.o_valid = (state_q == STREAM);
        strm.o_re    = re_q[idx_q];
        strm.o_im    = im_q[idx_q];
        strm.o_bin   = idx_q;
        strm.o_last  = at_last;
        o_busy       = (state_q == STREAM);
        o_overrun    = overrun_q;
        o_state_dbg  = state_q;
    end

endmodule
